// File: rtl/detector_jogada_pkg.sv
// Shared definitions for the debounced single-button play detector:
// FSM state codes, button-vector width and debounce default.
package detector_jogada_pkg;

  localparam int N_BOTOES                = 4;
  localparam int ESTADO_W                = 3;
  localparam int DEBOUNCE_CICLOS_DEFAULT = 1000;

  typedef enum logic [ESTADO_W-1:0] {
    OCIOSO      = 3'd0,
    FILTRANDO   = 3'd1,
    REGISTRA    = 3'd2,
    PRESSIONADO = 3'd3,
    SOLTANDO    = 3'd4
  } estado_t;

  // True when exactly one button is pressed.
  function automatic logic um_quente(input logic [N_BOTOES-1:0] v);
    return (v != '0) && ((v & (v - {{(N_BOTOES-1){1'b0}}, 1'b1})) == '0);
  endfunction

endpackage

// File: rtl/detector_jogada_sincronizador.sv
// Two-flop synchronizer for asynchronous level inputs, one chain per bit.
module sincronizador #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // NOTE: non-blocking assignments so sync_q takes the old meta_q, forming two stages.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/detector_jogada.sv
// Debounced push-button play detector: accepts a single, stable one-hot
// press, pulses jogada once, and re-arms only after a debounced release.
module detector_jogada
  import detector_jogada_pkg::*;
#(
  parameter int DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_DEFAULT
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_BOTOES-1:0] botoes,
  input  logic                limpa,
  output logic                jogada,
  output logic [N_BOTOES-1:0] botoes_reg,
  output logic [ESTADO_W-1:0] db_estado
);

  localparam int              CNT_W   = $clog2(DEBOUNCE_CICLOS);
  localparam logic [CNT_W-1:0] CNT_FIM = CNT_W'(DEBOUNCE_CICLOS - 1);

  logic [N_BOTOES-1:0] s;
  estado_t             estado_q, estado_d;
  logic [N_BOTOES-1:0] candidato_q, candidato_d;
  logic [N_BOTOES-1:0] botoes_reg_q, botoes_reg_d;
  logic [CNT_W-1:0]    cont_q, cont_d;

  sincronizador #(
    .WIDTH (N_BOTOES)
  ) u_sincronizador (
    .clock (clock),
    .reset (reset),
    .d     (botoes),
    .q     (s)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q     <= OCIOSO;
      candidato_q  <= '0;
      botoes_reg_q <= '0;
      cont_q       <= '0;
    end else begin
      estado_q     <= estado_d;
      candidato_q  <= candidato_d;
      botoes_reg_q <= botoes_reg_d;
      cont_q       <= cont_d;
    end
  end

  always_comb begin
    // NOTE: every output gets a hold default first, so no branch can infer a latch.
    estado_d     = estado_q;
    candidato_d  = candidato_q;
    botoes_reg_d = botoes_reg_q;
    cont_d       = cont_q;

    // A clear parks the FSM in SOLTANDO so a button still held must be released first.
    if (limpa) begin
      estado_d     = SOLTANDO;
      cont_d       = '0;
      botoes_reg_d = '0;
    end else begin
      case (estado_q)
        OCIOSO: begin
          if (um_quente(s)) begin
            candidato_d = s;
            cont_d      = '0;
            estado_d    = FILTRANDO;
          end
        end
        FILTRANDO: begin
          if (s != candidato_q) begin
            estado_d = OCIOSO;
          end else if (cont_q == CNT_FIM) begin
            estado_d     = REGISTRA;
            botoes_reg_d = candidato_q;
          end else begin
            cont_d = cont_q + CNT_W'(1);
          end
        end
        REGISTRA: begin
          estado_d = PRESSIONADO;
        end
        PRESSIONADO: begin
          if (s == '0) begin
            cont_d   = '0;
            estado_d = SOLTANDO;
          end
        end
        SOLTANDO: begin
          if (s != '0) begin
            estado_d = PRESSIONADO;
          end else if (cont_q == CNT_FIM) begin
            estado_d = OCIOSO;
          end else begin
            cont_d = cont_q + CNT_W'(1);
          end
        end
        default: begin
          estado_d = OCIOSO;
        end
      endcase
    end
  end

  assign jogada     = (estado_q == REGISTRA);
  assign botoes_reg = botoes_reg_q;
  assign db_estado  = estado_q;

endmodule
